sync_bin_counter4: RTL and testbench



---
 rtl/sync_bin_counter4_pkg.sv | 6 +
 rtl/sync_bin_counter4.sv | 56 +++++
 tb/tb_sync_bin_counter4.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_bin_counter4_pkg.sv
// Constants shared by struct74 parts that model 4-bit counter slices.
package sync_bin_counter4_pkg;

    localparam int COUNT_W = 4;

endpackage

// File: rtl/sync_bin_counter4.sv
// 74161-style 4-bit synchronous binary counter: async clear, sync load,
// ENP/ENT count enables and combinational ripple-carry out.
module sync_bin_counter4
    import sync_bin_counter4_pkg::*;
(
    input  logic pin1,   // CLR_n
    input  logic pin2,   // CLK
    input  logic pin3,   // A
    input  logic pin4,   // B
    input  logic pin5,   // C
    input  logic pin6,   // D
    input  logic pin7,   // ENP
    input  logic pin8,   // GND
    input  logic pin9,   // LOAD_n
    input  logic pin10,  // ENT
    output logic pin11,  // QD
    output logic pin12,  // QC
    output logic pin13,  // QB
    output logic pin14,  // QA
    output logic pin15,  // RCO
    input  logic pin16   // VCC
);

    logic [COUNT_W-1:0] r_q;
    logic [COUNT_W-1:0] w_q_next;
    logic [COUNT_W-1:0] w_load_data;
    logic               w_count_en;
    logic               w_unused_pins;

    // Supply pins exist only to keep the DIP footprint uniform.
    assign w_unused_pins = pin8 ^ pin16;

    assign w_load_data = {pin6, pin5, pin4, pin3};
    assign w_count_en  = pin7 & pin10;

    always_comb begin
        w_q_next = r_q;
        if (!pin9) begin
            w_q_next = w_load_data;
        end else if (w_count_en) begin
            w_q_next = r_q + 1'b1;
        end
    end

    always_ff @(posedge pin2 or negedge pin1) begin
        if (!pin1) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign {pin11, pin12, pin13, pin14} = r_q;
    assign pin15 = pin10 & (&r_q);

endmodule

// File: tb/tb_sync_bin_counter4.sv
// Bench for sync_bin_counter4: single part, a two-stage cascade and an
// RCO->inverter->LOAD_n loop, checked against a behavioural model.
module tb_sync_bin_counter4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr_n, a, b, c, d, enp, ent, load_n_drv, loop_mode;
    logic gnd = 1'b0;
    logic vcc = 1'b1;
    logic qa, qb, qc, qd, rco;
    logic w_load_n;

    assign w_load_n = loop_mode ? ~rco : load_n_drv;

    sync_bin_counter4 dut (
        .pin1(clr_n), .pin2(clk), .pin3(a), .pin4(b), .pin5(c), .pin6(d),
        .pin7(enp), .pin8(gnd), .pin9(w_load_n), .pin10(ent),
        .pin11(qd), .pin12(qc), .pin13(qb), .pin14(qa), .pin15(rco), .pin16(vcc)
    );

    // Two-stage cascade: RCO of stage 0 drives ENT of stage 1.
    logic c_clr_n, c_en;
    logic [3:0] c0_q, c1_q;
    logic c0_rco, c1_rco;

    sync_bin_counter4 u_c0 (
        .pin1(c_clr_n), .pin2(clk), .pin3(1'b0), .pin4(1'b0), .pin5(1'b0), .pin6(1'b0),
        .pin7(c_en), .pin8(gnd), .pin9(1'b1), .pin10(c_en),
        .pin11(c0_q[3]), .pin12(c0_q[2]), .pin13(c0_q[1]), .pin14(c0_q[0]),
        .pin15(c0_rco), .pin16(vcc)
    );

    sync_bin_counter4 u_c1 (
        .pin1(c_clr_n), .pin2(clk), .pin3(1'b0), .pin4(1'b0), .pin5(1'b0), .pin6(1'b0),
        .pin7(c_en), .pin8(gnd), .pin9(1'b1), .pin10(c0_rco),
        .pin11(c1_q[3]), .pin12(c1_q[2]), .pin13(c1_q[1]), .pin14(c1_q[0]),
        .pin15(c1_rco), .pin16(vcc)
    );

    int passed = 0;
    int total  = 0;
    logic chk_en = 1'b0;
    logic c_chk  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int q_val();
        return int'({qd, qc, qb, qa});
    endfunction

    // Behavioural model: plain integer arithmetic on the documented rules.
    int m_q = 0;
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_q = 0;
        end else begin
            bit do_load;
            do_load = loop_mode ? (ent && m_q == 15) : !load_n_drv;
            if (do_load) m_q = d * 8 + c * 4 + b * 2 + a;
            else if (enp && ent) m_q = (m_q + 1) % 16;
        end
    end

    int c_cnt = 0;
    always @(posedge clk or negedge c_clr_n) begin
        if (!c_clr_n) c_cnt = 0;
        else if (c_en) c_cnt = (c_cnt + 1) % 256;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", q_val(), m_q);
            check("model_rco", int'(rco), (ent && m_q == 15) ? 1 : 0);
        end
        if (c_chk) begin
            check("casc_q", int'({c1_q, c0_q}), c_cnt);
            check("casc_rco1", int'(c1_rco), (c_cnt == 255) ? 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_data(input logic [3:0] v);
        {d, c, b, a} = v;
    endtask

    initial begin
        clr_n = 1'b0; loop_mode = 1'b0; c_clr_n = 1'b0; c_en = 1'b0;
        set_data(4'h0); enp = 1'b0; ent = 1'b0; load_n_drv = 1'b1;

        // Clear held low with random inputs, including an active load.
        for (int i = 0; i < 4; i++) begin
            {a, b, c, d, enp, load_n_drv} = 6'($urandom);
            ent = 1'b1;
            tick();
            check("clr_q", q_val(), 0);
            check("clr_rco", int'(rco), 0);
        end

        // Release clear, count 17 edges from 0.
        clr_n = 1'b1; load_n_drv = 1'b1; enp = 1'b1; ent = 1'b1; set_data(4'h0);
        chk_en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check("count_q", q_val(), i % 16);
            check("count_rco", int'(rco), (i % 16 == 15) ? 1 : 0);
        end

        // Load wins over count.
        set_data(4'b1010); load_n_drv = 1'b0;
        tick();
        check("load_prio", q_val(), 10);

        // Hold at 7 with ENP low.
        set_data(4'h7);
        tick();
        load_n_drv = 1'b1; enp = 1'b0; ent = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold7", q_val(), 7);
        end

        // ENT low at 15: RCO gated off and q held.
        set_data(4'hF); load_n_drv = 1'b0; enp = 1'b1; ent = 1'b0;
        tick();
        load_n_drv = 1'b1;
        check("entlo_q", q_val(), 15);
        check("entlo_rco", int'(rco), 0);
        tick();
        check("entlo_hold", q_val(), 15);
        ent = 1'b1;
        #1;
        check("rco_comb", int'(rco), 1);
        tick();
        check("wrap_q", q_val(), 0);
        check("wrap_rco", int'(rco), 0);

        // Load of F with ENT=1 raises RCO after the load edge.
        set_data(4'hF); load_n_drv = 1'b0; enp = 1'b0; ent = 1'b1;
        check("preload_rco", int'(rco), 0);
        tick();
        check("loadF_rco", int'(rco), 1);

        // Count from E.
        set_data(4'hE);
        tick();
        load_n_drv = 1'b1; enp = 1'b1;
        tick();
        check("fromE_q", q_val(), 15);
        check("fromE_rco", int'(rco), 1);
        tick();
        check("fromE_wrap", q_val(), 0);

        // Async clear pulse mid-count at q=9, between edges.
        set_data(4'h8); load_n_drv = 1'b0;
        tick();
        load_n_drv = 1'b1;
        tick();
        check("at9", q_val(), 9);
        #2; clr_n = 1'b0; #1;
        check("async_clr_q", q_val(), 0);
        check("async_clr_rco", int'(rco), 0);
        clr_n = 1'b1;
        tick();
        check("post_clr", q_val(), 1);

        // Clear held across an edge with a pending load: clear wins.
        set_data(4'h5); load_n_drv = 1'b0; clr_n = 1'b0;
        tick();
        check("clr_vs_load", q_val(), 0);
        clr_n = 1'b1;
        tick();
        check("load_after_clr", q_val(), 5);

        // RCO->inverter->LOAD_n loop with DCBA=1100.
        load_n_drv = 1'b1; loop_mode = 1'b1; set_data(4'b1100); enp = 1'b1; ent = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("loop_reach15", q_val(), 15);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("loop_seq", q_val(), 12 + (i % 4));
        end
        loop_mode = 1'b0;

        // Cascade: 255 edges to FF, then wrap.
        c_clr_n = 1'b1; c_en = 1'b1; c_chk = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        check("casc_ff", int'({c1_q, c0_q}), 255);
        check("casc_ff_rco", int'(c1_rco), 1);
        tick();
        check("casc_wrap", int'({c1_q, c0_q}), 0);
        check("casc_wrap_rco", int'(c1_rco), 0);

        chk_en = 1'b0; c_chk = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
